// File: rtl/mem_arbiter.sv
// mem_arbiter: responder side of the byte-serial dcache/icache memory handshake.
// Arbitrates one byte per cycle onto the shared RAM/IO port (dcache has strict
// priority) and returns the completion one cycle later.
// Optional build macro: MEM_ARB_STATS_EN adds d_bytes, i_bytes and stall_cycles
// counters as extra outputs.
module mem_arbiter #(
    parameter int         ADDR_WIDTH = 18,
    parameter logic [1:0] IO_PREFIX  = 2'b11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d_get_en,
    input  logic                  d_write_mode,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [7:0]            d_data,
    output logic                  d_out_en,
    output logic [7:0]            d_content,
    input  logic                  i_get_en,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_out_en,
    output logic [7:0]            i_content,
    input  logic                  io_buffer_full,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]           d_bytes,
    output logic [31:0]           i_bytes,
    output logic [31:0]           stall_cycles
`endif
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_D    = 2'd1,
        OWN_I    = 2'd2
    } owner_e;

    owner_e     grant;
    owner_e     owner;
    logic       was_write;
    logic       d_io_blocked;
    logic [7:0] wbyte_q;
    logic [7:0] d_content_q;
    logic [7:0] i_content_q;

    // Current-cycle grant and combinational drive of the RAM/IO port.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        grant        = OWN_NONE;
        mem_a        = '0;
        mem_wr       = 1'b0;
        mem_dout     = 8'h00;
        // Only IO writes wait for the sink; IO reads and RAM traffic never stall.
        d_io_blocked = d_write_mode && (d_addr[ADDR_WIDTH-1 -: 2] == IO_PREFIX) && io_buffer_full;
        if (!rst) begin
            if (d_get_en && !d_io_blocked) begin
                grant = OWN_D;
            end else if (i_get_en) begin
                grant = OWN_I;
            end
        end
        case (grant)
            OWN_D: begin
                mem_a    = d_addr;
                mem_wr   = d_write_mode;
                mem_dout = d_data;
            end
            OWN_I: begin
                mem_a = i_addr;
            end
            default: ;
        endcase
    end

    // In-flight byte: who was granted last cycle, and the write byte to echo back.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            owner     <= OWN_NONE;
            was_write <= 1'b0;
            wbyte_q   <= 8'h00;
        end else begin
            owner     <= grant;
            was_write <= (grant == OWN_D) && d_write_mode;
            wbyte_q   <= d_data;
        end
    end

    // Completion: RAM byte arrives this cycle; content holds its last value when idle.
    always_comb begin
        d_out_en  = (owner == OWN_D);
        i_out_en  = (owner == OWN_I);
        d_content = d_content_q;
        i_content = i_content_q;
        if (owner == OWN_D) begin
            d_content = was_write ? wbyte_q : mem_din;
        end
        if (owner == OWN_I) begin
            i_content = mem_din;
        end
    end

    // Hold registers that keep the last delivered byte visible between completions.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_content_q <= 8'h00;
            i_content_q <= 8'h00;
        end else begin
            if (owner == OWN_D) d_content_q <= d_content;
            if (owner == OWN_I) i_content_q <= i_content;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic stall;

    // A cycle stalls when any requesting client is not the one granted.
    always_comb begin
        stall = (d_get_en && (grant != OWN_D)) || (i_get_en && (grant != OWN_I));
    end

    // Traffic and stall counters, free-running and wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_bytes      <= 32'd0;
            i_bytes      <= 32'd0;
            stall_cycles <= 32'd0;
        end else begin
            if (d_out_en) d_bytes      <= d_bytes + 32'd1;
            if (i_out_en) i_bytes      <= i_bytes + 32'd1;
            if (stall)    stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a one-cycle-latency byte RAM model.
module tb_mem_arbiter;

    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          d_get_en, d_write_mode, i_get_en, io_buffer_full;
    logic [AW-1:0] d_addr, i_addr;
    logic [7:0]    d_data;
    logic          d_out_en, i_out_en, mem_wr;
    logic [7:0]    d_content, i_content, mem_dout, mem_din;
    logic [AW-1:0] mem_a;
`ifdef MEM_ARB_STATS_EN
    logic [31:0]   d_bytes, i_bytes, stall_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .IO_PREFIX(2'b11)) dut (
        .clk(clk), .rst(rst),
        .d_get_en(d_get_en), .d_write_mode(d_write_mode), .d_addr(d_addr), .d_data(d_data),
        .d_out_en(d_out_en), .d_content(d_content),
        .i_get_en(i_get_en), .i_addr(i_addr), .i_out_en(i_out_en), .i_content(i_content),
        .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr)
`ifdef MEM_ARB_STATS_EN
        , .d_bytes(d_bytes), .i_bytes(i_bytes), .stall_cycles(stall_cycles)
`endif
    );

    // RAM/IO model: read data valid the cycle after the address; preloaded on the first edge.
    logic [7:0] ram [0:(1<<AW)-1];
    logic       ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            ram[18'h00000] <= 8'h5A;
            ram[18'h00001] <= 8'h3C;
            ram[18'h00040] <= 8'h77;
            ram[18'h00100] <= 8'h11;
            ram[18'h00101] <= 8'h22;
            ram[18'h00102] <= 8'h33;
            ram[18'h00103] <= 8'h44;
            ram[18'h30005] <= 8'h9E;
            ram_ready      <= 1'b1;
        end else if (mem_wr) begin
            ram[mem_a] <= mem_dout;
        end
        mem_din <= ram[mem_a];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        d_get_en = 1'b0; d_write_mode = 1'b0; d_addr = '0; d_data = 8'h00;
        i_get_en = 1'b0; i_addr = '0; io_buffer_full = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        d_get_en = 1'b1; d_write_mode = 1'b1; d_addr = 18'h00123; d_data = 8'hFF;
        i_get_en = 1'b1; i_addr = 18'h00456;
        #1;
        n_cmp++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL reset_mem_wr got=%b exp=0", mem_wr); end
        n_cmp++; if (mem_a !== 18'h0) begin n_err++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
        n_cmp++; if (mem_dout !== 8'h00) begin n_err++; $display("FAIL reset_mem_dout got=%h exp=00", mem_dout); end
        tick();
        n_cmp++; if (d_out_en !== 1'b0 || i_out_en !== 1'b0) begin n_err++; $display("FAIL reset_out_en got=%b%b exp=00", d_out_en, i_out_en); end
        n_cmp++; if (d_content !== 8'h00 || i_content !== 8'h00) begin n_err++; $display("FAIL reset_content got=%h/%h exp=00/00", d_content, i_content); end
`ifdef MEM_ARB_STATS_EN
        n_cmp++; if (d_bytes !== 0 || i_bytes !== 0 || stall_cycles !== 0) begin n_err++; $display("FAIL reset_stats got=%0d/%0d/%0d exp=0/0/0", d_bytes, i_bytes, stall_cycles); end
`endif
        idle_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_d_read_burst();
        logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
`ifdef MEM_ARB_STATS_EN
        logic [31:0] db0 = d_bytes;
`endif
        d_get_en = 1'b1; d_write_mode = 1'b0; d_addr = 18'h00100;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (mem_wr !== 1'b0 || mem_a !== 18'h00100 + k) begin n_err++; $display("FAIL rd_port[%0d] got wr=%b a=%h exp wr=0 a=%h", k, mem_wr, mem_a, 18'h00100 + k); end
            tick();
            n_cmp++; if (d_out_en !== 1'b1 || d_content !== exp_b[k]) begin n_err++; $display("FAIL rd_ack[%0d] got en=%b d=%h exp en=1 d=%h", k, d_out_en, d_content, exp_b[k]); end
            if (k < 3) d_addr = 18'h00101 + k;
            else d_get_en = 1'b0;
        end
        tick();
        n_cmp++; if (d_out_en !== 1'b0 || d_content !== 8'h44) begin n_err++; $display("FAIL rd_hold got en=%b d=%h exp en=0 d=44", d_out_en, d_content); end
`ifdef MEM_ARB_STATS_EN
        n_cmp++; if (d_bytes !== db0 + 4) begin n_err++; $display("FAIL rd_d_bytes got=%0d exp=%0d", d_bytes, db0 + 4); end
`endif
    endtask

    task automatic test_d_write_burst();
        d_get_en = 1'b1; d_write_mode = 1'b1; d_addr = 18'h00200; d_data = 8'hA0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (mem_wr !== 1'b1 || mem_a !== 18'h00200 + k || mem_dout !== 8'hA0 + k) begin n_err++; $display("FAIL wr_port[%0d] got wr=%b a=%h d=%h exp wr=1 a=%h d=%h", k, mem_wr, mem_a, mem_dout, 18'h00200 + k, 8'hA0 + k); end
            tick();
            n_cmp++; if (d_out_en !== 1'b1 || d_content !== 8'hA0 + k) begin n_err++; $display("FAIL wr_ack[%0d] got en=%b d=%h exp en=1 d=%h", k, d_out_en, d_content, 8'hA0 + k); end
            if (k < 3) begin d_addr = 18'h00201 + k; d_data = 8'hA1 + k; end
            else idle_inputs();
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (ram[18'h00200 + k] !== 8'hA0 + k) begin n_err++; $display("FAIL wr_ram[%0d] got=%h exp=%h", k, ram[18'h00200 + k], 8'hA0 + k); end
        end
        // Read one written byte back through the arbiter.
        d_get_en = 1'b1; d_addr = 18'h00202;
        tick();
        idle_inputs();
        n_cmp++; if (d_out_en !== 1'b1 || d_content !== 8'hA2) begin n_err++; $display("FAIL wr_readback got en=%b d=%h exp en=1 d=a2", d_out_en, d_content); end
        tick();
    endtask

    task automatic test_priority();
`ifdef MEM_ARB_STATS_EN
        logic [31:0] st0 = stall_cycles;
`endif
        d_get_en = 1'b1; d_write_mode = 1'b0; d_addr = 18'h00040;
        i_get_en = 1'b1; i_addr = 18'h00000;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++; if (mem_a !== 18'h00040) begin n_err++; $display("FAIL prio_port[%0d] got a=%h exp a=00040", k, mem_a); end
            tick();
            n_cmp++; if (d_out_en !== 1'b1 || i_out_en !== 1'b0 || d_content !== 8'h77) begin n_err++; $display("FAIL prio_ack[%0d] got d_en=%b i_en=%b d=%h exp 1/0/77", k, d_out_en, i_out_en, d_content); end
        end
        d_get_en = 1'b0;
        #1;
        n_cmp++; if (mem_a !== 18'h00000 || mem_wr !== 1'b0) begin n_err++; $display("FAIL prio_i_port got a=%h wr=%b exp a=0 wr=0", mem_a, mem_wr); end
        tick();
        i_get_en = 1'b0;
        n_cmp++; if (i_out_en !== 1'b1 || d_out_en !== 1'b0 || i_content !== 8'h5A) begin n_err++; $display("FAIL prio_i_ack got i_en=%b d_en=%b i=%h exp 1/0/5a", i_out_en, d_out_en, i_content); end
`ifdef MEM_ARB_STATS_EN
        n_cmp++; if (stall_cycles !== st0 + 2) begin n_err++; $display("FAIL prio_stall got=%0d exp=%0d", stall_cycles, st0 + 2); end
`endif
        tick();
    endtask

    task automatic test_io_block();
`ifdef MEM_ARB_STATS_EN
        logic [31:0] st0 = stall_cycles;
`endif
        io_buffer_full = 1'b1;
        d_get_en = 1'b1; d_write_mode = 1'b1; d_addr = 18'h30000; d_data = 8'h41;
        i_get_en = 1'b1; i_addr = 18'h00001;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (mem_wr !== 1'b0 || mem_a !== 18'h00001) begin n_err++; $display("FAIL io_blk_port[%0d] got wr=%b a=%h exp wr=0 a=00001", k, mem_wr, mem_a); end
            tick();
            n_cmp++; if (i_out_en !== 1'b1 || d_out_en !== 1'b0 || i_content !== 8'h3C) begin n_err++; $display("FAIL io_blk_ack[%0d] got i_en=%b d_en=%b i=%h exp 1/0/3c", k, i_out_en, d_out_en, i_content); end
        end
        io_buffer_full = 1'b0; i_get_en = 1'b0;
        #1;
        n_cmp++; if (mem_wr !== 1'b1 || mem_a !== 18'h30000 || mem_dout !== 8'h41) begin n_err++; $display("FAIL io_rel_port got wr=%b a=%h d=%h exp 1/30000/41", mem_wr, mem_a, mem_dout); end
        tick();
        n_cmp++; if (d_out_en !== 1'b1 || d_content !== 8'h41 || i_out_en !== 1'b0) begin n_err++; $display("FAIL io_rel_ack got d_en=%b d=%h i_en=%b exp 1/41/0", d_out_en, d_content, i_out_en); end
`ifdef MEM_ARB_STATS_EN
        n_cmp++; if (stall_cycles !== st0 + 3) begin n_err++; $display("FAIL io_stall got=%0d exp=%0d", stall_cycles, st0 + 3); end
`endif
        // IO reads proceed even while the write sink is full.
        io_buffer_full = 1'b1; d_write_mode = 1'b0; d_addr = 18'h30005;
        #1;
        n_cmp++; if (mem_wr !== 1'b0 || mem_a !== 18'h30005) begin n_err++; $display("FAIL io_rd_port got wr=%b a=%h exp 0/30005", mem_wr, mem_a); end
        tick();
        idle_inputs();
        n_cmp++; if (d_out_en !== 1'b1 || d_content !== 8'h9E) begin n_err++; $display("FAIL io_rd_ack got en=%b d=%h exp 1/9e", d_out_en, d_content); end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        d_get_en = 1'b1; d_write_mode = 1'b0; d_addr = 18'h00102;
        rst = 1'b1;
        #1;
        n_cmp++; if (mem_a !== 18'h0 || mem_wr !== 1'b0) begin n_err++; $display("FAIL rstmid_port got a=%h wr=%b exp 0/0", mem_a, mem_wr); end
        tick();
        rst = 1'b0;
        idle_inputs();
        n_cmp++; if (d_out_en !== 1'b0 || i_out_en !== 1'b0) begin n_err++; $display("FAIL rstmid_out_en got=%b%b exp=00", d_out_en, i_out_en); end
        n_cmp++; if (d_content !== 8'h00 || i_content !== 8'h00) begin n_err++; $display("FAIL rstmid_content got=%h/%h exp=00/00", d_content, i_content); end
        tick();
        n_cmp++; if (d_out_en !== 1'b0) begin n_err++; $display("FAIL rstmid_after got en=%b exp=0", d_out_en); end
`ifdef MEM_ARB_STATS_EN
        n_cmp++; if (d_bytes !== 0 || i_bytes !== 0 || stall_cycles !== 0) begin n_err++; $display("FAIL rstmid_stats got=%0d/%0d/%0d exp=0/0/0", d_bytes, i_bytes, stall_cycles); end
`endif
    endtask

    task automatic test_idle();
`ifdef MEM_ARB_STATS_EN
        // Put some history in the counters before the idle window.
        i_get_en = 1'b1; i_addr = 18'h00000;
        tick();
        idle_inputs();
        tick();
        begin
            logic [31:0] db0 = d_bytes, ib0 = i_bytes, st0 = stall_cycles;
`endif
        idle_inputs();
        for (int k = 0; k < 10; k++) begin
            #1;
            n_cmp++; if (mem_wr !== 1'b0 || mem_a !== 18'h0 || d_out_en !== 1'b0 || i_out_en !== 1'b0) begin n_err++; $display("FAIL idle[%0d] got wr=%b a=%h den=%b ien=%b exp all 0", k, mem_wr, mem_a, d_out_en, i_out_en); end
            tick();
        end
`ifdef MEM_ARB_STATS_EN
            n_cmp++; if (d_bytes !== db0 || i_bytes !== ib0 || stall_cycles !== st0) begin n_err++; $display("FAIL idle_stats got=%0d/%0d/%0d exp=%0d/%0d/%0d", d_bytes, i_bytes, stall_cycles, db0, ib0, st0); end
        end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_d_read_burst();
        test_d_write_burst();
        test_priority();
        test_io_block();
        test_reset_mid_burst();
        test_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
